hazard_control_unit: RTL

Parametrised hazard controller for the five-stage pipelined RISC-V core. It generates EX-stage operand forwarding selects and detects load-use hazards. It sequences multi-cycle multiply/divide (MDU) occupancy of EX with an internal FSM, flushes on taken branches/jumps, and keeps saturating stall/flush performance counters. Sits beside the datapath and drives the enable/clear inputs of the IF/ID, ID/EX and EX/MEM pipeline registers.

---
 rtl/hazard_control_unit_if.sv | 25 ++
 rtl/hazard_control_unit.sv | 73 +++++++
 2 files changed

// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: hazard-controller signal bundle between the datapath (master) and the controller (slave).
interface hazard_control_unit_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    logic [RA_W-1:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic             load_e, reg_write_m, reg_write_w, pc_src_e, mdu_start_e, perf_clr;
    logic [1:0]       forward_a_e, forward_b_e;
    logic             stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy;
    logic [CNT_W-1:0] stall_count, flush_count;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        output load_e, reg_write_m, reg_write_w, pc_src_e, mdu_start_e, perf_clr,
        input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
        input  flush_d, flush_e, flush_m, mdu_busy, stall_count, flush_count
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        input  load_e, reg_write_m, reg_write_w, pc_src_e, mdu_start_e, perf_clr,
        output forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
        output flush_d, flush_e, flush_m, mdu_busy, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: EX forwarding, load-use detection, MDU occupancy FSM and branch flushes
// with saturating stall/flush performance counters.
module hazard_control_unit #(
    parameter int RA_W    = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    hazard_control_unit_if.slave hz
);
    localparam int CW = $clog2(MDU_LAT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             lu, mdu_stall;

    assign hz.forward_a_e = (hz.reg_write_m && hz.rs1_e == hz.rd_m && hz.rs1_e != '0) ? 2'b10 :
                            (hz.reg_write_w && hz.rs1_e == hz.rd_w && hz.rs1_e != '0) ? 2'b01 : 2'b00;
    assign hz.forward_b_e = (hz.reg_write_m && hz.rs2_e == hz.rd_m && hz.rs2_e != '0) ? 2'b10 :
                            (hz.reg_write_w && hz.rs2_e == hz.rd_w && hz.rs2_e != '0) ? 2'b01 : 2'b00;

    assign lu = hz.load_e && hz.rd_e != '0 && (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d) && !hz.pc_src_e;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdu_stall = 1'b0;
        if (state_q == IDLE) begin
            if (hz.mdu_start_e && MDU_LAT > 1) begin
                state_d   = BUSY;
                cnt_d     = CW'(MDU_LAT - 1);
                mdu_stall = 1'b1;
            end
        end else begin
            cnt_d     = cnt_q - 1'b1;
            mdu_stall = cnt_q > CW'(1);
            state_d   = cnt_q > CW'(1) ? BUSY : IDLE;
        end
    end

    assign hz.stall_f  = lu || mdu_stall;
    assign hz.stall_d  = lu || mdu_stall;
    assign hz.stall_e  = mdu_stall;
    assign hz.flush_d  = hz.pc_src_e;
    // A held MDU op must never be killed, so its stall masks the load-use bubble.
    assign hz.flush_e  = hz.pc_src_e || (lu && !mdu_stall);
    assign hz.flush_m  = mdu_stall;
    assign hz.mdu_busy = state_q == BUSY;

    assign stall_cnt_d = hz.perf_clr ? '0 : (hz.stall_f && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    assign flush_cnt_d = hz.perf_clr ? '0 : (hz.flush_e && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_count = stall_cnt_q;
    assign hz.flush_count = flush_cnt_q;
endmodule
